// File: rtl/div_32bit_seq_if.sv
// Operand/result handshake bundle between the EXU and the iterative divider.
interface div_32bit_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/div_32bit_seq.sv
// Iterative restoring divider, one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU semantics.
module div_32bit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  div_32bit_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH-1:0] orig_dvd;
  logic [WIDTH-1:0] orig_dsr;
  logic [WIDTH:0]   rem_r;
  logic             neg_q, neg_r, sgn_op;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  logic             accept;
  logic             dvd_neg, dsr_neg;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             div_zero, overflow;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;

  always_comb begin
    dvd_neg  = bus.is_signed & bus.dividend[WIDTH-1];
    dsr_neg  = bus.is_signed & bus.divisor[WIDTH-1];
    accept   = (state == IDLE) && bus.in_valid && !flush;
    shifted  = {rem_r[WIDTH-1:0], work[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_abs};
    div_zero = (orig_dsr == '0);
    overflow = sgn_op && (orig_dvd == MIN_NEG) && (orig_dsr == '1);
    q_fix    = neg_q ? -work : work;
    r_fix    = neg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
    if (div_zero) begin
      q_fix = '1;
      r_fix = orig_dvd;
    end else if (overflow) begin
      q_fix = orig_dvd;
      r_fix = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (count == CW'(WIDTH)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counts 0..WIDTH-1 perform the WIDTH iterations; the extra count==WIDTH
  // cycle registers the sign fix-up, giving the fixed WIDTH+1 latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      work        <= '0;
      dsr_abs     <= '0;
      orig_dvd    <= '0;
      orig_dsr    <= '0;
      rem_r       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      sgn_op      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else if (accept) begin
      work     <= dvd_neg ? -bus.dividend : bus.dividend;
      dsr_abs  <= dsr_neg ? -bus.divisor : bus.divisor;
      orig_dvd <= bus.dividend;
      orig_dsr <= bus.divisor;
      sgn_op   <= bus.is_signed;
      neg_q    <= dvd_neg ^ dsr_neg;
      neg_r    <= dvd_neg;
      rem_r    <= '0;
      count    <= '0;
    end else if (state == CALC && !flush) begin
      if (count != CW'(WIDTH)) begin
        rem_r <= trial[WIDTH] ? shifted : trial;
        work  <= {work[WIDTH-2:0], ~trial[WIDTH]};
        count <= count + CW'(1);
      end else begin
        quotient_r  <= q_fix;
        remainder_r <= r_fix;
      end
    end
  end
endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed self-checking bench for div_32bit_seq: vector table plus handshake corner cases.
`timescale 1ns/1ps
module tb_div_32bit_seq;
  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad = 0;

  div_32bit_seq_if #(.WIDTH(32)) bus ();

  div_32bit_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.is_signed = ~sgn;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    int   cyc;
    int   seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,        32'hFFFFFFFD,  32'hFFFFFFFF};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'h2,        32'h7FFFFFFC,  32'h1};
    vecs[3]  = '{1'b1, 32'h12345678,   32'h0,        32'hFFFFFFFF,  32'h12345678};
    vecs[4]  = '{1'b0, 32'h12345678,   32'h0,        32'hFFFFFFFF,  32'h12345678};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'h0};
    vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h0,         32'h80000000};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'h1};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9,   32'h0,        32'hFFFFFFFF,  32'hFFFFFFF9};
    vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'h1,        32'hFFFFFFFF,  32'h0};
    vecs[11] = '{1'b0, 32'd5,          32'd9,        32'd0,         32'd5};
    vecs[12] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,         32'd0};
    vecs[13] = '{1'b1, 32'h80000000,   32'h1,        32'h80000000,  32'h0};
    vecs[14] = '{1'b1, 32'h80000000,   32'h2,        32'hC0000000,  32'h0};

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_quotient",  bus.quotient,       32'd0);
    chk("reset_remainder", bus.remainder,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_busy", i), 32'(bus.in_ready), 32'd0);
      wait_result(cyc);
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'd33);
      chk($sformatf("vec%0d_q", i), bus.quotient, vecs[i].q);
      chk($sformatf("vec%0d_r", i), bus.remainder, vecs[i].r);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_consumed", i), {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    end

    // Backpressure: result must hold while out_ready is low; in_valid is ignored.
    bus.out_ready = 1'b0;
    start_op(1'b0, 32'd100, 32'd7);
    wait_result(cyc);
    chk("bp_latency", 32'(cyc), 32'd33);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 32'd5;
      bus.divisor  = 32'd1;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_hs", k), {30'd0, bus.in_ready, bus.out_valid}, 32'b01);
      chk($sformatf("bp_hold%0d_q", k), bus.quotient, 32'd14);
      chk($sformatf("bp_hold%0d_r", k), bus.remainder, 32'd2);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);

    // Flush during CALC cycle 5 abandons the operation.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // Flush together with in_valid in IDLE must not accept.
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_blocks_accept", 32'(bus.in_ready), 32'd1);

    start_op(1'b0, 32'd9, 32'd3);
    wait_result(cyc);
    chk("post_flush_latency", 32'(cyc), 32'd33);
    chk("post_flush_q", bus.quotient, 32'd3);
    chk("post_flush_r", bus.remainder, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while a result waits in DONE.
    bus.out_ready = 1'b0;
    start_op(1'b0, 32'd100, 32'd7);
    wait_result(cyc);
    chk("rst_done_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("rst_async_q", bus.quotient, 32'd0);
    chk("rst_async_r", bus.remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    start_op(1'b0, 32'd9, 32'd3);
    wait_result(cyc);
    chk("post_rst_latency", 32'(cyc), 32'd33);
    chk("post_rst_q", bus.quotient, 32'd3);
    chk("post_rst_r", bus.remainder, 32'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
